// File: rtl/rom_reader.sv
// Initiator for a byte-wide combinational ROM: fetch LEN bytes from BASE and stream them out.
// Latency: start -> address out in 1 cycle, first byte valid in 2; peak rate 1 byte per 2 clocks.
// Backpressure: a presented byte holds (data_o/valid_o steady) until ready_i; no fetch runs meanwhile.
module rom_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  // One bit wider than the address so a zero length can stand for the full 2**ADDR_W bytes.
  logic [ADDR_W:0]   rem_q, rem_d;

  // Next-state logic: sequence idle -> fetch -> present (-> fetch ...) -> done.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rem_d   = {(len_i == '0), len_i};
          state_d = FETCH;
        end
      end
      FETCH: begin
        // rom_addr_o has been stable all cycle, so the combinational ROM data is settled.
        data_d  = rom_data_i;
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          rem_d   = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = DONE;
          end else begin
            // Wrap past the top of the ROM is intentional; only the count ends a walk.
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rem_q   <= rem_d;
    end
  end

  assign rom_addr_o = addr_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

endmodule
